fetch_prefetch_unit: RTL and testbench
======================================

# fetch_prefetch_unit

Parametrised instruction-fetch stage with a request/acknowledge instruction-memory port and a small prefetch queue. It keeps at most one memory request in flight, buffers returned instructions with their PCs, and presents them to decode through a valid/ready handshake. A branch or jump redirect flushes the queue and squashes any in-flight response. It sits between instruction memory and the decode/controller stage of the MIPS pipeline.

## Interface
- ADDR_W, 32, PC and memory address width (≥ 3)
- INST_W, 32, instruction width
- DEPTH, 4, prefetch queue entries (power of two, ≥ 2)
- RESET_PC, 0, PC fetched first after reset (word aligned)

Ports (clock, then reset):
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- mem_req  out  1  fetch request; held until mem_ack
- mem_addr  out  ADDR_W  fetch address; stable while mem_req=1
- mem_ack  in  1  response valid this cycle; only sampled while mem_req=1
- mem_rdata  in  INST_W  instruction, valid with mem_ack
- redirect  in  1  branch/jump taken, single-cycle pulse
- redirect_pc  in  ADDR_W  target PC, sampled with redirect
- out_valid  out  1  queue head valid
- out_ready  in  1  decode accepts head
- out_inst  out  INST_W  head instruction
- out_pc  out  ADDR_W  head PC
- out_npc  out  ADDR_W  out_pc + 4, modulo 2^ADDR_W
- fault  out  1  misaligned redirect (only with FETCH_ALIGN_CHK_EN)

## Operation
- fetch_pc register: address of the next request. Advances by 4 on every accepted mem_ack. Wraps modulo 2^ADDR_W.
- FSM states:
  - IDLE: mem_req=0.
  - REQ: mem_req=1, mem_addr=fetch_pc.
  - DROP: mem_req=1 at the old address. The response is discarded.
- IDLE→REQ when credit is available and the unit is not faulted. Credit means queue count plus in-flight count is less than DEPTH.
- REQ on mem_ack: push {fetch_pc, mem_rdata} into the queue. Stay in REQ if credit remains after the push; otherwise go to IDLE.
- Redirect has priority over every other event in the same cycle:
  - Flush the queue. out_valid=0 the next cycle.
  - fetch_pc ← redirect_pc.
  - REQ without mem_ack → DROP.
  - REQ with mem_ack → data discarded, state → REQ at the new PC.
  - IDLE → REQ.
- DROP on mem_ack: discard data, go to REQ at fetch_pc. A second redirect while in DROP updates fetch_pc and stays in DROP.
- Queue pop: out_valid & out_ready. A push and a pop in the same cycle are both honoured, including when the queue is full (the credit rule prevents overflow).
- Decode handshake: out_inst, out_pc and out_npc are held stable while out_valid=1 and out_ready=0.

## Timing
- Reset values:
  - mem_req=0, mem_addr=RESET_PC, out_valid=0.
  - out_inst=0, out_pc=0, out_npc=0, fault=0.
  - fetch_pc=RESET_PC, state IDLE, queue empty.
- First cycle after reset deassertion: go to REQ, with mem_req=1 on the following edge.
- Latency: mem_ack in cycle t gives out_valid=1 in cycle t+1 (registered queue write).
- Throughput: one instruction per cycle when mem_ack is high every cycle and decode is ready. mem_addr advances on the cycle after each ack.
- Redirect in cycle t: mem_addr=redirect_pc visible in cycle t+1, unless in DROP. First new instruction out no earlier than t+2.
- Reset asserted mid-request: the in-flight request is abandoned immediately. The memory must tolerate a withdrawn mem_req on reset.

## Configuration
- Macro: FETCH_ALIGN_CHK_EN.
- Defined:
  - A redirect with redirect_pc[1:0] ≠ 0 sets fault=1 and flushes the queue.
  - No new request is issued; any outstanding one completes and is dropped.
  - fault clears, and fetch resumes, only on reset or an aligned redirect.
- Undefined:
  - The fault port is absent.
  - redirect_pc[1:0] is forced to 0.

## Structure
- Package fetch_pkg:
  - INST_BYTES=4
  - FSM state enum {IDLE, REQ, DROP}
  - default RESET_PC
  - queue entry struct {pc, inst}
- Sub-module fetch_fifo:
  - synchronous FIFO with DEPTH entries of ADDR_W+INST_W bits.
  - push/pop/flush inputs; count, empty and full outputs; flush has priority over push.

## Test plan
- Reset, mem_ack tied high, out_ready=1 → out_pc sequence 0,4,8,12… one per cycle from cycle 3; out_npc = out_pc+4.
- out_ready=0, DEPTH=4 → exactly 4 acks accepted, then mem_req=0. Release ready → four entries drain in order and fetch resumes.
- Redirect to 0x100 while in REQ with mem_ack delayed 3 cycles → the late response is discarded, then mem_addr=0x100. No instruction with the old PC appears after the redirect.
- Redirect in the same cycle as mem_ack, and a second redirect while in DROP → only the last target's instructions are delivered.
- fetch_pc=2^ADDR_W−4 → the next request is at address 0, with out_npc=0 for that entry.
- FETCH_ALIGN_CHK_EN, redirect to 0x102 → fault=1, no further mem_req rising edge. Aligned redirect to 0x200 → fault=0 and fetch resumes at 0x200.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package fetch_pkg;

    localparam int          INST_BYTES   = 4;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DROP
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: synchronous FIFO holding {pc, inst} entries.
// Flush overrides push and pop; a push into a full queue is honoured only with a pop.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset; the head is masked by the top while the queue is empty.
    always_ff @(posedge clk) begin
        if (do_push && !flush)
            mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch stage: one outstanding memory request feeding a prefetch queue.
// Misaligned-redirect fault detection is built only when FETCH_ALIGN_CHK_EN is defined.
module fetch_prefetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [INST_W-1:0] mem_rdata,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [ADDR_W-1:0] out_pc,
    output logic [ADDR_W-1:0] out_npc
`ifdef FETCH_ALIGN_CHK_EN
    ,
    output logic              fault
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = ADDR_W + INST_W;

    fetch_state_t      state_q;
    fetch_state_t      state_d;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] drop_addr;
    logic [ADDR_W-1:0] target_pc;
    logic [EW-1:0]     head;
    logic [ADDR_W-1:0] head_pc;
    logic [INST_W-1:0] head_inst;
    logic [CW-1:0]     count;
    logic              empty;
    logic              full;
    logic              push;
    logic              pop;
    logic              credit_after_push;
    logic              fault_q;
    logic              fault_d;

`ifdef FETCH_ALIGN_CHK_EN
    logic misaligned;

    assign misaligned = |redirect_pc[1:0];
    assign target_pc  = redirect_pc;
    assign fault_d    = redirect ? misaligned : fault_q;
    assign fault      = fault_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            fault_q <= 1'b0;
        else
            fault_q <= fault_d;
    end
`else
    logic unused_align;

    assign unused_align = ^redirect_pc[1:0];
    assign target_pc    = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign fault_d      = 1'b0;
    assign fault_q      = 1'b0;
`endif

    assign push = (state_q == REQ) && mem_ack && !redirect;
    assign pop  = !empty && out_ready;

    // After a push the slot of the completed request is free again, so only the queue counts.
    assign credit_after_push = pop || (count < CW'(DEPTH - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            fetch_pc  <= RESET_PC;
            drop_addr <= RESET_PC;
        end else begin
            state_q <= state_d;
            if (redirect)
                fetch_pc <= target_pc;
            else if (push)
                fetch_pc <= fetch_pc + ADDR_W'(INST_BYTES);
            if (redirect && (state_q == REQ) && !mem_ack)
                drop_addr <= fetch_pc;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (redirect)
                    state_d = fault_d ? IDLE : REQ;
                else if (!full && !fault_q)
                    state_d = REQ;
            end
            REQ: begin
                if (redirect) begin
                    if (mem_ack)
                        state_d = fault_d ? IDLE : REQ;
                    else
                        state_d = DROP;
                end else if (mem_ack) begin
                    state_d = credit_after_push ? REQ : IDLE;
                end
            end
            DROP: begin
                if (mem_ack)
                    state_d = fault_d ? IDLE : REQ;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_req  = (state_q != IDLE);
        mem_addr = (state_q == DROP) ? drop_addr : fetch_pc;
    end

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({fetch_pc, mem_rdata}),
        .pop       (pop),
        .flush     (redirect),
        .head      (head),
        .count     (count),
        .empty     (empty),
        .full      (full)
    );

    assign {head_pc, head_inst} = head;
    assign out_valid = !empty;
    assign out_inst  = empty ? '0 : head_inst;
    assign out_pc    = empty ? '0 : head_pc;
    assign out_npc   = empty ? '0 : head_pc + ADDR_W'(INST_BYTES);

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Randomized self-checking bench for fetch_prefetch_unit against a PC-stream model.
// Build with FETCH_ALIGN_CHK_EN to exercise the fault path instead of address masking.
module tb_fetch_prefetch_unit;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [31:0] out_npc;
`ifdef FETCH_ALIGN_CHK_EN
    logic        fault;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] npc;
    } obs_t;

    obs_t        seen[$];
    int          checks = 0;
    int          errors = 0;
    int          ack_pct = 0;
    int          ready_pct = 0;
    int          acks = 0;
    int          req_rises = 0;
    int          addr_glitch = 0;
    int          hold_glitch = 0;
    logic        prev_req = 1'b0;
    logic        prev_pending = 1'b0;
    logic        prev_hold = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [31:0] prev_pc = '0;
    logic [31:0] prev_inst = '0;

    fetch_prefetch_unit #(
        .ADDR_W   (32),
        .INST_W   (32),
        .DEPTH    (4),
        .RESET_PC (32'h0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_inst    (out_inst),
        .out_pc      (out_pc),
        .out_npc     (out_npc)
`ifdef FETCH_ALIGN_CHK_EN
        ,
        .fault       (fault)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Instruction memory contents are a fixed scramble of the address.
    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // One cycle from a negedge to the next: observe, drive memory/decode, capture pops.
    task automatic step();
        if (prev_pending && (!mem_req || mem_addr !== prev_addr))
            addr_glitch++;
        if (prev_hold && (!out_valid || out_pc !== prev_pc || out_inst !== prev_inst))
            hold_glitch++;
        if (mem_req && !prev_req)
            req_rises++;
        mem_ack   = mem_req && ($urandom_range(0, 99) < ack_pct);
        mem_rdata = mem_ack ? inst_of(mem_addr) : $urandom();
        out_ready = ($urandom_range(0, 99) < ready_pct);
        if (out_valid && out_ready)
            seen.push_back('{out_pc, out_inst, out_npc});
        if (mem_ack)
            acks++;
        prev_req     = mem_req;
        prev_pending = mem_req && !mem_ack;
        prev_addr    = mem_addr;
        prev_hold    = out_valid && !out_ready && !redirect;
        prev_pc      = out_pc;
        prev_inst    = out_inst;
        @(posedge clk);
        @(negedge clk);
        redirect = 1'b0;
    endtask

    task automatic clear_monitor();
        seen.delete();
        acks         = 0;
        req_rises    = 0;
        addr_glitch  = 0;
        hold_glitch  = 0;
        prev_req     = 1'b0;
        prev_pending = 1'b0;
        prev_hold    = 1'b0;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        mem_ack     = 1'b0;
        mem_rdata   = '0;
        out_ready   = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        clear_monitor();
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        mem_ack     = 1'b0;
        mem_rdata   = '0;
        out_ready   = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_req: got %b expected 0", mem_req); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_mem_addr: got %h expected 0", mem_addr); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if ({out_inst, out_pc, out_npc} !== 96'h0) begin errors++; $display("[TB] FAIL reset_outputs: got %h %h %h expected zeros", out_inst, out_pc, out_npc); end
`ifdef FETCH_ALIGN_CHK_EN
        checks++; if (fault !== 1'b0) begin errors++; $display("[TB] FAIL reset_fault: got %b expected 0", fault); end
`endif
        reset = 1'b0;
        clear_monitor();
        checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL release_idle: got mem_req %b expected 0", mem_req); end
        step();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin errors++; $display("[TB] FAIL first_request: got req %b addr %h expected 1 00000000", mem_req, mem_addr); end
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc;
        do_reset();
        ack_pct = 100; ready_pct = 100;
        step();
        repeat (20) step();
        checks++; if (seen.size() != 19) begin errors++; $display("[TB] FAIL stream_throughput: got %0d entries expected 19", seen.size()); end
        exp_pc = 32'h0;
        foreach (seen[i]) begin
            checks++;
            if (seen[i].pc !== exp_pc || seen[i].inst !== inst_of(exp_pc) || seen[i].npc !== exp_pc + 32'd4) begin
                errors++; $display("[TB] FAIL stream_entry%0d: got pc %h inst %h npc %h expected pc %h", i, seen[i].pc, seen[i].inst, seen[i].npc, exp_pc);
            end
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_pc;
        do_reset();
        ack_pct = 100; ready_pct = 0;
        repeat (15) step();
        checks++; if (acks != 4) begin errors++; $display("[TB] FAIL bp_ack_count: got %0d expected 4", acks); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL bp_req_stops: got %b expected 0", mem_req); end
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin errors++; $display("[TB] FAIL bp_head: got valid %b pc %h expected 1 00000000", out_valid, out_pc); end
        checks++; if (hold_glitch != 0) begin errors++; $display("[TB] FAIL bp_hold: got %0d changes expected 0", hold_glitch); end
        ready_pct = 100;
        repeat (30) step();
        checks++; if (seen.size() < 8 || acks <= 4) begin errors++; $display("[TB] FAIL bp_resume: got %0d entries %0d acks expected >=8 and >4", seen.size(), acks); end
        exp_pc = 32'h0;
        foreach (seen[i]) begin
            checks++;
            if (seen[i].pc !== exp_pc || seen[i].inst !== inst_of(exp_pc) || seen[i].npc !== exp_pc + 32'd4) begin
                errors++; $display("[TB] FAIL bp_entry%0d: got pc %h inst %h expected pc %h", i, seen[i].pc, seen[i].inst, exp_pc);
            end
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    task automatic test_redirect_late();
        logic [31:0] old_addr;
        logic [31:0] exp_pc;
        do_reset();
        ack_pct = 100; ready_pct = 0;
        repeat (4) step();
        ack_pct = 0;
        step();
        old_addr = mem_addr;
        redirect = 1'b1; redirect_pc = 32'h100;
        step();
        seen.delete();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL late_flush: got out_valid %b expected 0", out_valid); end
        checks++; if (mem_req !== 1'b1 || mem_addr !== old_addr) begin errors++; $display("[TB] FAIL late_drop_addr: got req %b addr %h expected 1 %h", mem_req, mem_addr, old_addr); end
        repeat (2) step();
        ack_pct = 100;
        step();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin errors++; $display("[TB] FAIL late_new_addr: got req %b addr %h expected 1 00000100", mem_req, mem_addr); end
        ack_pct = 70; ready_pct = 100;
        repeat (30) step();
        checks++; if (seen.size() == 0 || addr_glitch != 0) begin errors++; $display("[TB] FAIL late_resume: got %0d entries %0d addr changes expected >0 and 0", seen.size(), addr_glitch); end
        exp_pc = 32'h100;
        foreach (seen[i]) begin
            checks++;
            if (seen[i].pc !== exp_pc || seen[i].inst !== inst_of(exp_pc)) begin
                errors++; $display("[TB] FAIL late_entry%0d: got pc %h inst %h expected pc %h", i, seen[i].pc, seen[i].inst, exp_pc);
            end
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    task automatic test_redirect_same_ack();
        logic [31:0] exp_pc;
        do_reset();
        ack_pct = 100; ready_pct = 100;
        repeat (6) step();
        checks++; if (mem_req !== 1'b1) begin errors++; $display("[TB] FAIL same_pre_req: got %b expected 1", mem_req); end
        redirect = 1'b1; redirect_pc = 32'h400;
        step();
        seen.delete();
        checks++; if (out_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h400) begin errors++; $display("[TB] FAIL same_ack_redirect: got valid %b req %b addr %h expected 0 1 00000400", out_valid, mem_req, mem_addr); end
        ack_pct = 0;
        step();
        redirect = 1'b1; redirect_pc = 32'h500;
        step();
        redirect = 1'b1; redirect_pc = 32'h600;
        step();
        seen.delete();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h400) begin errors++; $display("[TB] FAIL double_drop_addr: got req %b addr %h expected 1 00000400", mem_req, mem_addr); end
        ack_pct = 60; ready_pct = 70;
        repeat (40) step();
        checks++; if (seen.size() == 0) begin errors++; $display("[TB] FAIL double_resume: got 0 entries expected >0"); end
        exp_pc = 32'h600;
        foreach (seen[i]) begin
            checks++;
            if (seen[i].pc !== exp_pc || seen[i].inst !== inst_of(exp_pc)) begin
                errors++; $display("[TB] FAIL double_entry%0d: got pc %h inst %h expected pc %h", i, seen[i].pc, seen[i].inst, exp_pc);
            end
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc;
        do_reset();
        ack_pct = 100; ready_pct = 100;
        repeat (2) step();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFF0;
        step();
        seen.delete();
        repeat (12) step();
        checks++;
        if (seen.size() < 6 || seen[3].npc !== 32'h0 || seen[4].pc !== 32'h0) begin
            errors++; $display("[TB] FAIL wrap_boundary: got %0d entries expected entry3 npc 0 and entry4 pc 0", seen.size());
        end
        exp_pc = 32'hFFFF_FFF0;
        foreach (seen[i]) begin
            checks++;
            if (seen[i].pc !== exp_pc || seen[i].inst !== inst_of(exp_pc) || seen[i].npc !== exp_pc + 32'd4) begin
                errors++; $display("[TB] FAIL wrap_entry%0d: got pc %h npc %h expected pc %h", i, seen[i].pc, seen[i].npc, exp_pc);
            end
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    task automatic test_alignment();
        logic [31:0] exp_pc;
        do_reset();
        ack_pct = 100; ready_pct = 100;
        repeat (3) step();
        redirect = 1'b1; redirect_pc = 32'h102;
        step();
        seen.delete();
`ifdef FETCH_ALIGN_CHK_EN
        begin
            int rises;
            checks++; if (fault !== 1'b1) begin errors++; $display("[TB] FAIL fault_set: got %b expected 1", fault); end
            rises = req_rises;
            repeat (10) step();
            checks++; if (req_rises != rises || mem_req !== 1'b0 || seen.size() != 0) begin errors++; $display("[TB] FAIL fault_stalls: got %0d new rises req %b %0d entries expected 0 0 0", req_rises - rises, mem_req, seen.size()); end
            redirect = 1'b1; redirect_pc = 32'h200;
            step();
            seen.delete();
            checks++; if (fault !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h200) begin errors++; $display("[TB] FAIL fault_clear: got fault %b req %b addr %h expected 0 1 00000200", fault, mem_req, mem_addr); end
            exp_pc = 32'h200;
        end
`else
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin errors++; $display("[TB] FAIL align_mask: got req %b addr %h expected 1 00000100", mem_req, mem_addr); end
        exp_pc = 32'h100;
`endif
        repeat (10) step();
        checks++; if (seen.size() == 0) begin errors++; $display("[TB] FAIL align_resume: got 0 entries expected >0"); end
        foreach (seen[i]) begin
            checks++;
            if (seen[i].pc !== exp_pc || seen[i].inst !== inst_of(exp_pc)) begin
                errors++; $display("[TB] FAIL align_entry%0d: got pc %h expected %h", i, seen[i].pc, exp_pc);
            end
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        ack_pct = 100; ready_pct = 100;
        repeat (5) step();
        ack_pct = 0;
        step();
        #2 reset = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b0 || mem_addr !== 32'h0 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_mid: got req %b addr %h valid %b expected 0 00000000 0", mem_req, mem_addr, out_valid); end
        @(negedge clk);
        reset = 1'b0;
        clear_monitor();
    endtask

    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] tgt;
        obs_t        e;
        logic        do_redir;
        do_reset();
        exp_pc = 32'h0;
        for (int n = 0; n < 400; n++) begin
            ack_pct   = 60;
            ready_pct = 60;
            do_redir  = ($urandom_range(0, 99) < 6);
            tgt       = 32'($urandom_range(0, 16383)) << 2;
            if (do_redir) begin
                redirect    = 1'b1;
                redirect_pc = tgt;
            end
            step();
            while (seen.size() > 0) begin
                e = seen.pop_front();
                checks++;
                if (e.pc !== exp_pc || e.inst !== inst_of(exp_pc) || e.npc !== exp_pc + 32'd4) begin
                    errors++; $display("[TB] FAIL random_entry: got pc %h inst %h npc %h expected pc %h", e.pc, e.inst, e.npc, exp_pc);
                end
                exp_pc = e.pc + 32'd4;
            end
            if (do_redir) begin
                exp_pc = tgt;
                checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL random_flush: got out_valid %b expected 0", out_valid); end
            end
        end
        checks++; if (addr_glitch != 0 || hold_glitch != 0) begin errors++; $display("[TB] FAIL random_stability: got %0d addr and %0d head changes expected 0", addr_glitch, hold_glitch); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_late();
        test_redirect_same_ack();
        test_wrap();
        test_alignment();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
